dmem_responder: RTL

//  Data-memory responder for the CPU's store/load port: address_to_mem, data_to_mem, write_enable.

---
 rtl/dmem_responder_if.sv | 31 +++
 rtl/dmem_responder.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/dmem_responder_if.sv
// CPU data-port bundle between the CPU (master) and dmem_responder (slave).
// Address, store data and strobe go in; load data and buffer status come back.
interface dmem_responder_if;
    logic [31:0] address_to_mem;
    logic [31:0] data_to_mem;
    logic        write_enable;
    logic [31:0] read_data;
    logic        wbuf_full;
    logic        wbuf_empty;
    logic        addr_fault;

    modport master (
        output address_to_mem,
        output data_to_mem,
        output write_enable,
        input  read_data,
        input  wbuf_full,
        input  wbuf_empty,
        input  addr_fault
    );

    modport slave (
        input  address_to_mem,
        input  data_to_mem,
        input  write_enable,
        output read_data,
        output wbuf_full,
        output wbuf_empty,
        output addr_fault
    );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: word RAM with combinational loads and an optional posted
// write buffer (enabled by defining DMEM_WBUF_EN) drained on cycles with no store.
module dmem_responder #(
    parameter int MEM_WORDS  = 64,
    parameter int WBUF_DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    dmem_responder_if.slave  bus
);

    localparam int AW = $clog2(MEM_WORDS);

    if ((1 << AW) != MEM_WORDS || WBUF_DEPTH < 2 ||
        (WBUF_DEPTH & (WBUF_DEPTH - 1)) != 0) begin : g_bad_param
        $error("dmem_responder: MEM_WORDS and WBUF_DEPTH must be powers of 2, WBUF_DEPTH >= 2");
    end

    // ------------------------------------------------------------------
    // Address decode shared by loads and stores
    // ------------------------------------------------------------------
    logic [AW-1:0] word_idx;
    logic          addr_ok;
    logic          store_ok;
    logic          store_bad;

    assign word_idx  = bus.address_to_mem[AW+1:2];
    assign addr_ok   = (bus.address_to_mem[1:0] == 2'b00) &&
                       (bus.address_to_mem[31:AW+2] == '0);
    assign store_ok  = bus.write_enable && addr_ok;
    assign store_bad = bus.write_enable && !addr_ok;

    // ------------------------------------------------------------------
    // Word RAM
    // ------------------------------------------------------------------
    logic [31:0]   ram [MEM_WORDS];
    logic          ram_we;
    logic [AW-1:0] ram_waddr;
    logic [31:0]   ram_wdata;

    // NOTE: storage arrays carry no reset; contents persist across reset and only
    // the control state (pointers, count, flags) is cleared.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            ram[ram_waddr] <= ram_wdata;
        end
    end

    // ------------------------------------------------------------------
    // Sticky illegal-store flag
    // ------------------------------------------------------------------
    logic fault_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fault_q <= 1'b0;
        end else if (store_bad) begin
            fault_q <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Write path: posted buffer or direct RAM write
    // ------------------------------------------------------------------
    logic        fwd_hit;
    logic [31:0] fwd_data;
    logic        full_q;
    logic        empty_q;

`ifdef DMEM_WBUF_EN
    localparam int PW = $clog2(WBUF_DEPTH);
    localparam int CW = PW + 1;

    typedef struct packed {
        logic [AW-1:0] idx;
        logic [31:0]   data;
    } wbuf_entry_t;

    wbuf_entry_t   wbuf [WBUF_DEPTH];
    logic [PW-1:0] head_q;
    logic [PW-1:0] tail_q;
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;
    logic          at_cap;
    logic          do_enq;
    logic          do_drain;

    // A store into a full buffer retires the head at the same edge, so nothing is dropped.
    assign at_cap   = (count_q == CW'(WBUF_DEPTH));
    assign do_enq   = store_ok;
    assign do_drain = store_ok ? at_cap : (count_q != '0);

    // NOTE: combinational blocks use blocking assignments with a default first,
    // so every path assigns every output and no latch is inferred.
    always_comb begin
        count_d = count_q;
        if (do_enq && !do_drain) begin
            count_d = count_q + CW'(1);
        end else if (!do_enq && do_drain) begin
            count_d = count_q - CW'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            if (do_drain) head_q <= head_q + PW'(1);
            if (do_enq)   tail_q <= tail_q + PW'(1);
            count_q <= count_d;
            full_q  <= (count_d == CW'(WBUF_DEPTH));
            empty_q <= (count_d == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (do_enq) begin
            wbuf[tail_q] <= '{idx: word_idx, data: bus.data_to_mem};
        end
    end

    assign ram_we    = do_drain && !reset;
    assign ram_waddr = wbuf[head_q].idx;
    assign ram_wdata = wbuf[head_q].data;

    // Scan oldest to youngest so the youngest matching entry is the one that sticks.
    always_comb begin : fwd_scan
        logic [PW-1:0] slot;
        slot     = '0;
        fwd_hit  = 1'b0;
        fwd_data = '0;
        for (int k = 0; k < WBUF_DEPTH; k++) begin
            slot = head_q + PW'(k);
            if ((CW'(k) < count_q) && (wbuf[slot].idx == word_idx)) begin
                fwd_hit  = 1'b1;
                fwd_data = wbuf[slot].data;
            end
        end
    end
`else
    assign ram_we    = store_ok && !reset;
    assign ram_waddr = word_idx;
    assign ram_wdata = bus.data_to_mem;
    assign fwd_hit   = 1'b0;
    assign fwd_data  = '0;
    assign full_q    = 1'b0;
    assign empty_q   = 1'b1;
`endif

    // ------------------------------------------------------------------
    // Load path and status outputs
    // ------------------------------------------------------------------
    assign bus.read_data  = !addr_ok ? 32'h0 :
                            fwd_hit  ? fwd_data : ram[word_idx];
    assign bus.wbuf_full  = full_q;
    assign bus.wbuf_empty = empty_q;
    assign bus.addr_fault = fault_q;

endmodule
